// File: rtl/ccr_pkg.sv
// Shared definitions for the condition-code register stage: opcodes, flag bit
// positions, branch condition codes and the per-opcode flag update mask.
package ccr_pkg;

    // ALU opcodes as presented in EX.
    localparam logic [3:0] OP_MOV  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_RLC  = 4'b0101;
    localparam logic [3:0] OP_RRC  = 4'b0110;
    localparam logic [3:0] OP_SETC = 4'b0111;
    localparam logic [3:0] OP_CLRC = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_NEG  = 4'b1010;
    localparam logic [3:0] OP_INC  = 4'b1011;
    localparam logic [3:0] OP_DEC  = 4'b1100;

    // Flag positions inside the 4-bit {V,C,N,Z} vector.
    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 3;

    typedef enum logic [2:0] {
        BrZ      = 3'b000,
        BrN      = 3'b001,
        BrC      = 3'b010,
        BrV      = 3'b011,
        BrNz     = 3'b100,
        BrNc     = 3'b101,
        BrAlways = 3'b110,
        BrNever  = 3'b111
    } br_cond_e;

    // Which flags an opcode is allowed to write, ordered {V,C,N,Z}.
    function automatic logic [3:0] upd_mask(input logic [3:0] op);
        logic [3:0] m;
        m = 4'b0000;
        case (op)
            OP_ADD, OP_SUB, OP_NEG, OP_INC, OP_DEC: m = 4'b1111;
            OP_AND, OP_OR, OP_NOT:                  m = 4'b0011;
            OP_RLC, OP_RRC:                         m = 4'b0111;
            OP_SETC, OP_CLRC:                       m = 4'b0100;
            default:                                m = 4'b0000;
        endcase
        return m;
    endfunction

    // Branch condition test against a {V,C,N,Z} flag vector.
    function automatic logic br_cond_met(input logic [2:0] cond, input logic [3:0] f);
        logic met;
        met = 1'b0;
        case (br_cond_e'(cond))
            BrZ:      met = f[FLAG_Z];
            BrN:      met = f[FLAG_N];
            BrC:      met = f[FLAG_C];
            BrV:      met = f[FLAG_V];
            BrNz:     met = ~f[FLAG_Z];
            BrNc:     met = ~f[FLAG_C];
            BrAlways: met = 1'b1;
            BrNever:  met = 1'b0;
            default:  met = 1'b0;
        endcase
        return met;
    endfunction

endpackage

// File: rtl/ccr_unit_if.sv
// EX-stage side of the condition-code unit: ALU flags, pipeline control,
// branch request/result and interrupt flag save/restore.
interface ccr_unit_if;
    logic       ex_valid;
    logic [3:0] alu_op;
    logic       alu_z;
    logic       alu_n;
    logic       alu_c;
    logic       alu_v;
    logic       stall;
    logic       flush;
    logic       br_eval;
    logic [2:0] br_cond;
    logic       int_save;
    logic       int_restore;
    logic [3:0] ccr;
    logic       br_taken;
    logic       br_valid;
    logic       stk_ovf;
    logic       stk_unf;

    // Pipeline driving the unit.
    modport master (
        output ex_valid, alu_op, alu_z, alu_n, alu_c, alu_v, stall, flush,
        output br_eval, br_cond, int_save, int_restore,
        input  ccr, br_taken, br_valid, stk_ovf, stk_unf
    );

    // The condition-code unit itself.
    modport slave (
        input  ex_valid, alu_op, alu_z, alu_n, alu_c, alu_v, stall, flush,
        input  br_eval, br_cond, int_save, int_restore,
        output ccr, br_taken, br_valid, stk_ovf, stk_unf
    );
endinterface

// File: rtl/ccr_shadow_stack.sv
// LIFO of saved flag vectors for nested interrupts. A simultaneous push and
// pop is treated as a pop only; overflow/underflow attempts leave the stack
// untouched and raise a one-cycle pulse on the following cycle.
module ccr_shadow_stack #(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [3:0] wdata,
    output logic [3:0] rdata,
    output logic       empty,
    output logic       ovf,
    output logic       unf
);

    localparam int unsigned PTR_W = $clog2(DEPTH + 1);
    // Slot count rounded to a power of two so the pointer indexes it exactly.
    localparam int unsigned SLOTS = 2 ** PTR_W;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [3:0]       mem_q [SLOTS];
    logic             full;
    logic             do_push, do_pop;
    logic             ovf_d, unf_d;

    // Pointer arithmetic and pulse generation.
    always_comb begin
        full    = (ptr_q == PTR_W'(DEPTH));
        empty   = (ptr_q == '0);
        do_pop  = pop & ~empty;
        do_push = push & ~pop & ~full;
        ovf_d   = push & ~pop & full;
        unf_d   = pop & empty;
        ptr_d   = ptr_q;
        if (do_pop) begin
            ptr_d = ptr_q - PTR_W'(1);
        end else if (do_push) begin
            ptr_d = ptr_q + PTR_W'(1);
        end
        // Index wraps when empty; callers gate use of rdata with empty.
        rdata = mem_q[ptr_q - PTR_W'(1)];
    end

    // Pointer and status pulses; reset empties the stack.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            ovf   <= ovf_d;
            unf   <= unf_d;
        end
    end

    // Entry storage needs no reset; contents below the pointer are don't-care.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/ccr_unit.sv
// Condition-code register stage after the 8-bit ALU. Latches masked ALU flags,
// resolves branches on the bypassed next-flag value, and saves/restores flags
// across interrupts through a shadow stack.
module ccr_unit
    import ccr_pkg::*;
#(
    parameter int unsigned SHADOW_DEPTH = 2,
    parameter logic [3:0]  CCR_RESET    = 4'b0000
) (
    input  logic       clk,
    input  logic       rst,
    ccr_unit_if.slave  bus
);

    logic [3:0] ccr_q, ccr_d, ccr_next;
    logic [3:0] alu_f, mask;
    logic       upd, br_go, cond_met;
    logic       br_valid_q, br_taken_q;
    logic [3:0] stk_top;
    logic       stk_empty, stk_ovf, stk_unf;

    ccr_shadow_stack #(
        .DEPTH (SHADOW_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.int_save),
        .pop   (bus.int_restore),
        .wdata (ccr_next),
        .rdata (stk_top),
        .empty (stk_empty),
        .ovf   (stk_ovf),
        .unf   (stk_unf)
    );

    // Masked flag merge, branch test on the bypassed value, restore override.
    always_comb begin
        alu_f          = 4'b0000;
        alu_f[FLAG_Z]  = bus.alu_z;
        alu_f[FLAG_N]  = bus.alu_n;
        alu_f[FLAG_C]  = bus.alu_c;
        alu_f[FLAG_V]  = bus.alu_v;
        mask           = upd_mask(bus.alu_op);
        upd            = bus.ex_valid & ~bus.stall & ~bus.flush;
        ccr_next       = ccr_q;
        if (upd) begin
            ccr_next = (alu_f & mask) | (ccr_q & ~mask);
        end
        br_go    = bus.br_eval & ~bus.stall & ~bus.flush;
        cond_met = br_cond_met(bus.br_cond, ccr_next);
        // A successful pop wins over any same-cycle ALU update.
        ccr_d    = (bus.int_restore && !stk_empty) ? stk_top : ccr_next;
    end

    // Committed flags and registered branch decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            ccr_q      <= CCR_RESET;
            br_valid_q <= 1'b0;
            br_taken_q <= 1'b0;
        end else begin
            ccr_q      <= ccr_d;
            br_valid_q <= br_go;
            br_taken_q <= br_go & cond_met;
        end
    end

    assign bus.ccr      = ccr_q;
    assign bus.br_valid = br_valid_q;
    assign bus.br_taken = br_taken_q;
    assign bus.stk_ovf  = stk_ovf;
    assign bus.stk_unf  = stk_unf;

endmodule

// File: tb/tb_ccr_unit.sv
// Self-checking bench for ccr_unit: a behavioural model pushes expected
// outputs to a scoreboard when each cycle's stimulus is driven; they are
// popped and compared after the clock edge. Directed checks pin the key cases.
module tb_ccr_unit;

    localparam int unsigned DEPTH   = 2;
    localparam logic [3:0]  CCR_RST = 4'b0000;

    typedef struct {
        string      tag;
        logic [3:0] ccr;
        logic       bv;
        logic       bt;
        logic       ovf;
        logic       unf;
    } exp_t;

    logic clk;
    logic rst;
    ccr_unit_if bus_if ();

    ccr_unit #(
        .SHADOW_DEPTH (DEPTH),
        .CCR_RESET    (CCR_RST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         n_checks = 0;
    int         n_fail   = 0;
    exp_t       sb[$];
    logic [3:0] m_ccr;
    logic [3:0] m_stk[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Flags each opcode may write, {V,C,N,Z}.
    function automatic logic [3:0] m_mask(input logic [3:0] op);
        case (op)
            4'd1, 4'd2, 4'd10, 4'd11, 4'd12: return 4'b1111;
            4'd3, 4'd4, 4'd9:                return 4'b0011;
            4'd5, 4'd6:                      return 4'b0111;
            4'd7, 4'd8:                      return 4'b0100;
            default:                         return 4'b0000;
        endcase
    endfunction

    function automatic logic m_cond(input logic [2:0] bc, input logic [3:0] f);
        case (bc)
            3'd0:    return f[0];
            3'd1:    return f[1];
            3'd2:    return f[2];
            3'd3:    return f[3];
            3'd4:    return ~f[0];
            3'd5:    return ~f[2];
            3'd6:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // One clock: drive, model, push expectation, clock, pop and compare.
    task automatic step(input string tag, input logic r, input logic v, input logic [3:0] op,
                        input logic [3:0] f, input logic st, input logic fl, input logic be,
                        input logic [2:0] bc, input logic sv, input logic rs);
        exp_t       e;
        logic [3:0] nxt;
        logic       go;
        rst                = r;
        bus_if.ex_valid    = v;
        bus_if.alu_op      = op;
        bus_if.alu_v       = f[3];
        bus_if.alu_c       = f[2];
        bus_if.alu_n       = f[1];
        bus_if.alu_z       = f[0];
        bus_if.stall       = st;
        bus_if.flush       = fl;
        bus_if.br_eval     = be;
        bus_if.br_cond     = bc;
        bus_if.int_save    = sv;
        bus_if.int_restore = rs;
        e.tag = tag;
        if (r) begin
            m_ccr = CCR_RST;
            m_stk.delete();
            e.bv = 1'b0; e.bt = 1'b0; e.ovf = 1'b0; e.unf = 1'b0;
        end else begin
            nxt = m_ccr;
            if (v && !st && !fl) begin
                for (int i = 0; i < 4; i++) begin
                    if (m_mask(op)[i]) nxt[i] = f[i];
                end
            end
            go    = be & ~st & ~fl;
            e.bv  = go;
            e.bt  = go & m_cond(bc, nxt);
            e.ovf = sv & ~rs & (m_stk.size() == DEPTH);
            e.unf = rs & (m_stk.size() == 0);
            if (rs && m_stk.size() > 0) begin
                m_ccr = m_stk.pop_back();
            end else begin
                m_ccr = nxt;
                if (sv && !rs && m_stk.size() < DEPTH) m_stk.push_back(nxt);
            end
        end
        e.ccr = m_ccr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check_eq({e.tag, "_ccr"}, 32'(bus_if.ccr), 32'(e.ccr));
            check_eq({e.tag, "_bv"}, 32'(bus_if.br_valid), 32'(e.bv));
            check_eq({e.tag, "_bt"}, 32'(bus_if.br_taken), 32'(e.bt));
            check_eq({e.tag, "_ovf"}, 32'(bus_if.stk_ovf), 32'(e.ovf));
            check_eq({e.tag, "_unf"}, 32'(bus_if.stk_unf), 32'(e.unf));
        end
    endtask

    task automatic alu(input string tag, input logic [3:0] op, input logic [3:0] f);
        step(tag, 1'b0, 1'b1, op, f, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0);
    endtask

    task automatic idle(input string tag, input logic sv, input logic rs);
        step(tag, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd7, sv, rs);
    endtask

    initial begin
        m_ccr = CCR_RST;
        step("rst0", 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        step("rst1", 1'b1, 1'b1, 4'd1, 4'hF, 1'b0, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0);
        check_eq("reset_ccr", 32'(bus_if.ccr), 32'(CCR_RST));

        alu("add", 4'd1, 4'b1110);
        check_eq("add_ccr", 32'(bus_if.ccr), 32'h0E);
        alu("add2", 4'd1, 4'b1100);
        alu("and", 4'd3, 4'b0001);
        check_eq("and_keeps_cv", 32'(bus_if.ccr), 32'h0D);
        alu("clrc", 4'd8, 4'b0000);
        check_eq("clrc_ccr", 32'(bus_if.ccr), 32'h09);

        step("sub_br", 1'b0, 1'b1, 4'd2, 4'b0001, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
        check_eq("bypass_taken", 32'({bus_if.br_valid, bus_if.br_taken}), 32'h3);
        step("sub_stall", 1'b0, 1'b1, 4'd2, 4'b0010, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
        check_eq("stall_ccr", 32'(bus_if.ccr), 32'h01);
        check_eq("stall_bv", 32'(bus_if.br_valid), 32'h0);

        alu("mk0011", 4'd1, 4'b0011);
        idle("push1", 1'b1, 1'b0);
        alu("mk0101", 4'd1, 4'b0101);
        idle("push2", 1'b1, 1'b0);
        idle("push3", 1'b1, 1'b0);
        check_eq("ovf_pulse", 32'(bus_if.stk_ovf), 32'h1);
        idle("after_ovf", 1'b0, 1'b0);
        check_eq("ovf_one_cycle", 32'(bus_if.stk_ovf), 32'h0);
        idle("pop1", 1'b0, 1'b1);
        check_eq("pop1_ccr", 32'(bus_if.ccr), 32'h05);
        idle("pop2", 1'b0, 1'b1);
        check_eq("pop2_ccr", 32'(bus_if.ccr), 32'h03);
        idle("pop3", 1'b0, 1'b1);
        check_eq("unf_pulse", 32'({bus_if.stk_unf, bus_if.ccr}), 32'h13);

        alu("mk0010", 4'd1, 4'b0010);
        idle("push4", 1'b1, 1'b0);
        step("pop_vs_add", 1'b0, 1'b1, 4'd1, 4'b1111, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 1'b1);
        check_eq("pop_overrides", 32'(bus_if.ccr), 32'h02);

        step("flush_inc", 1'b0, 1'b1, 4'd11, 4'b1000, 1'b0, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0);
        check_eq("flush_ccr", 32'(bus_if.ccr), 32'h02);
        idle("push5", 1'b1, 1'b0);
        step("rst_mid", 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        idle("pop_after_rst", 1'b0, 1'b1);
        check_eq("rst_empties", 32'(bus_if.stk_unf), 32'h1);

        for (int c = 0; c < 8; c++) begin
            step("cond", 1'b0, 1'b1, 4'd1, 4'(c * 5), 1'b0, 1'b0, 1'b1, 3'(c), 1'b0, 1'b0);
        end

        for (int k = 0; k < 200; k++) begin
            step("rnd", 1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 4'($urandom), 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ccr_unit.md
Name: ccr_unit

Overview:
- Condition-code register stage directly downstream of the 8-bit ALU in the EX stage.
- Latches the ALU Z/N/C/V flags using a per-opcode update mask. The mask lets logical ops preserve C/V and lets SETC/CLRC touch only C.
- Resolves conditional branches against the bypassed flag value.
- Saves and restores flags on interrupt entry and return through a small shadow stack.

Parameters:
- SHADOW_DEPTH, 2, number of nested interrupt flag-save slots (1..4).
- CCR_RESET, 4'b0000, CCR value after reset, ordered {V,C,N,Z}.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- ex_valid  in  1  a valid ALU instruction is in EX this cycle.
- alu_op  in  4  opcode presented to the ALU this cycle.
- alu_z, alu_n, alu_c, alu_v  in  1 each  ALU flag outputs, same cycle.
- stall  in  1  EX held; blocks CCR update and branch resolution.
- flush  in  1  EX squashed; blocks CCR update and branch resolution.
- br_eval  in  1  branch in decode requests resolution.
- br_cond  in  3  branch condition code.
- int_save  in  1  interrupt entry; push flags.
- int_restore  in  1  RTI; pop flags.
- ccr  out  4  committed flags {V,C,N,Z}.
- br_taken  out  1  registered branch decision.
- br_valid  out  1  br_taken is meaningful this cycle.
- stk_ovf  out  1  one-cycle pulse: push while full.
- stk_unf  out  1  one-cycle pulse: pop while empty.

Behaviour:
- Reset: synchronous, active-high.
  - ccr = CCR_RESET.
  - br_taken, br_valid, stk_ovf, stk_unf = 0.
  - Stack pointer = 0; stack contents are don't-care.
- Update mask per alu_op:
  - 0001 ADD, 0010 SUB, 1010 NEG, 1011 INC, 1100 DEC: write ZNCV.
  - 0011 AND, 0100 OR, 1001 NOT: write ZN.
  - 0101 RLC, 0110 RRC: write ZNC.
  - 0111 SETC, 1000 CLRC: write C only.
  - 0000 MOV and 1101..1111: write nothing.
- upd = ex_valid & ~stall & ~flush.
- ccr_next is combinational: each masked bit takes the ALU flag when upd=1; unmasked bits keep ccr.
- Normal path: ccr <= ccr_next at the edge, i.e. 1-cycle latency from ALU flags to ccr.
- Branch conditions, evaluated on ccr_next so a younger branch sees the flags of the op currently in EX:
  - 000 Z, 001 N, 010 C, 011 V.
  - 100 ~Z, 101 ~C.
  - 110 always, 111 never.
- Branch outputs are registered:
  - br_valid <= br_eval & ~stall & ~flush.
  - br_taken <= cond & (br_eval & ~stall & ~flush); br_taken is 0 whenever br_valid is 0.
- Shadow stack: LIFO of 4-bit entries, pointer 0..SHADOW_DEPTH.
  - Push on int_save: writes ccr_next, pointer +1.
  - Pop on int_restore: ccr <= top entry, pointer -1. The pop overrides any same-cycle ALU update.
  - int_save and int_restore in the same cycle: restore only; save ignored.
  - Push while full: ignored, stack unchanged, stk_ovf=1 for one cycle.
  - Pop while empty: ignored, ccr follows the normal update path, stk_unf=1 for one cycle.
  - stall and flush do not gate int_save or int_restore.
- Priority: rst > int_restore > ALU update.
- rst asserted mid-sequence (e.g. stack partially full) empties the stack immediately at that edge.

Decomposition:
- Shared package ccr_pkg holds:
  - ALU opcode localparams (MOV..DEC, 4'b0000..4'b1100).
  - Flag bit indices (Z=0, N=1, C=2, V=3).
  - Branch condition codes.
  - A function mapping opcode to 4-bit update mask.
- One sub-module, ccr_shadow_stack:
  - Parameterised depth, push/pop, data in/out.
  - full/empty flags; ovf/unf pulses.

Test Plan:
- Reset then ADD with flags z=0,n=1,c=1,v=1, ex_valid=1 -> ccr=4'b1110 next cycle; ccr=CCR_RESET during reset.
- ccr=4'b1100, then AND with z=1,n=0,c=0,v=0 -> ccr=4'b1101 (C and V preserved). Then CLRC -> ccr=4'b1001.
- SUB with z=1 and br_eval=1, br_cond=000 in the same cycle -> next cycle br_valid=1, br_taken=1. Same stimulus with stall=1 -> ccr unchanged, br_valid=0.
- Push with ccr=4'b0011, push with ccr=4'b0101, third push -> stk_ovf pulses once. Pops restore 4'b0101 then 4'b0011. Third pop -> stk_unf pulses, ccr unchanged.
- int_restore together with a valid ADD (flags 4'b1111) and a non-empty stack holding 4'b0010 -> ccr=4'b0010.
- flush=1 with a valid INC (v=1) -> ccr unchanged. rst asserted with 1 entry pushed -> next pop raises stk_unf.
